// File: rtl/init_seq_pkg.sv
// Shared types and default constants for the power-up init sequencer.
package init_seq_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_RUN    = 3'd1,
    ST_GAP    = 3'd2,
    ST_WORK   = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  localparam int DEF_NUM_STAGES     = 2;
  localparam int DEF_SETTLE_CYCLES  = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;
  localparam int DEF_MAX_RETRIES    = 3;

  function automatic int stage_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int settle, input int timeout);
    return $clog2((settle > timeout) ? settle : timeout);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Clearable up-counter with terminal-count flag; holds at the limit until cleared.
module seq_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_clear,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] count_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else if (i_clear) begin
      count_q <= '0;
    end else if (!o_tc) begin
      count_q <= count_q + W'(1);
    end
  end

  assign o_tc = (count_q == i_limit);

endmodule

// File: rtl/init_sequencer.sv
// Walks NUM_STAGES init stages (settle, run until done or timeout, gap),
// retrying timed-out stages, then parks in WORK or FAIL until restarted.
module init_sequencer
  import init_seq_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  localparam int STAGE_W       = stage_width(NUM_STAGES)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NUM_STAGES-1:0] i_stage_done,
  input  logic                  i_restart,
  output logic [NUM_STAGES-1:0] o_stage_start,
  output logic                  o_device_work_start,
  output logic                  o_busy,
  output logic                  o_error,
  output logic [STAGE_W-1:0]    o_fail_stage,
  output logic [3:0]            o_retry_cnt,
  output state_t                o_dbg_state
);

  localparam int CNT_W = count_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RUN_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(NUM_STAGES - 1);
  localparam logic [3:0]         RETRY_LIMIT = 4'(MAX_RETRIES);

  state_t             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [STAGE_W-1:0] fail_q, fail_d;
  logic [3:0]         retry_q, retry_d;
  logic               tmr_clear, tmr_tc;
  logic [CNT_W-1:0]   tmr_limit;

  // One timer serves both phases: it restarts from 0 on every state change.
  assign tmr_limit = (state_q == ST_RUN) ? RUN_LAST : SETTLE_LAST;
  assign tmr_clear = (state_d != state_q) ||
                     !((state_q == ST_SETTLE) || (state_q == ST_RUN));

  seq_timer #(.W(CNT_W)) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (tmr_clear),
    .i_limit   (tmr_limit),
    .o_tc      (tmr_tc)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_SETTLE;
      stage_q <= '0;
      fail_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      fail_q  <= fail_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    fail_d  = fail_q;
    retry_d = retry_q;
    case (state_q)
      ST_SETTLE: begin
        if (tmr_tc) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Completion wins over a timeout landing in the same cycle.
        if (i_stage_done[stage_q]) begin
          state_d = ST_GAP;
        end else if (tmr_tc) begin
          fail_d = stage_q;
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_GAP: begin
        if (stage_q == LAST_STAGE) begin
          state_d = ST_WORK;
        end else begin
          stage_d = stage_q + STAGE_W'(1);
          state_d = ST_SETTLE;
        end
      end
      ST_WORK, ST_FAIL: begin
        if (i_restart) begin
          stage_d = '0;
          retry_d = '0;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_comb begin
    o_stage_start = '0;
    if (state_q == ST_RUN) o_stage_start[stage_q] = 1'b1;
  end

  assign o_device_work_start = (state_q == ST_WORK);
  assign o_busy              = (state_q == ST_SETTLE) || (state_q == ST_RUN) ||
                               (state_q == ST_GAP);
  assign o_error             = (state_q == ST_FAIL);
  assign o_fail_stage        = fail_q;
  assign o_retry_cnt         = retry_q;
  assign o_dbg_state         = state_q;

endmodule
